// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM states, default width and
// the bit-counter width helper.
package serial_add_pkg;

    // Default operand / result width in bits.
    localparam int DEFAULT_WIDTH = 8;

    // Controller states: waiting, shifting bits through the adder cell,
    // and the single-cycle completion state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to count from 0 to width-1; never less than one bit so the
    // counter exists even for a one-bit adder.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full adder used as the shared arithmetic cell of the serial
// adder. Purely combinational.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half_sum;

    // One-bit sum and carry generate/propagate.
    always_comb begin
        half_sum = a ^ b;
        sum      = half_sum ^ cin;
        cout     = (a & b) | (cin & half_sum);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. An accepted start latches both operands and
// the carry-in, then one bit per clock (LSB first) is pushed through a single
// full-adder cell. The finished word and carry are published together on the
// edge that processes the MSB, so the outputs never show partial results.
//
// Handshake: start is a level sampled on each rising edge; it is honoured
// only in IDLE or DONE and ignored while busy. done is a one-cycle pulse in
// the cycle after the final bit; sum/cout stay valid until the next done.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             bit_a;
    logic             bit_b;
    logic             fa_sum;
    logic             fa_cout;

    // Select the operand bits addressed by the bit counter.
    always_comb begin
        bit_a = a_q[cnt_q];
        bit_b = b_q[cnt_q];
    end

    fa_cell u_fa (
        .a    (bit_a),
        .b    (bit_b),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Next-state and datapath update; every register holds unless changed.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                // Start is deliberately not looked at here.
                res_d[cnt_q] = fa_sum;
                carry_d      = fa_cout;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = res_d;
                    cout_d  = fa_cout;
                    state_d = DONE;
                end
            end

            DONE: begin
                // A start here chains straight into the next addition.
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any addition in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Status and result outputs come straight from registers.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule
